// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_t;

  localparam int TIMEOUT_DEF = 256;
  localparam int NUM_LANES   = 4;

  // Load formatting context captured when the request is launched.
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
    logic       rd;
  } ld_ctl_t;

  // Byte enables for a given size/offset; size 2'b11 behaves as a word.
  function automatic logic [NUM_LANES-1:0] byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_en = 4'b0001 << off;
      SZ_HALF: byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate store data across every lane it could land in.
  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      SZ_BYTE: lane_wdata = {4{wd[7:0]}};
      SZ_HALF: lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load lane select and sign/zero extension.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  // Pick the addressed lane, then extend from its MSB unless unsigned.
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: result = {{24{~uns & b[7]}}, b};
      SZ_HALF: result = {{16{~uns & h[15]}}, h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack port sequencing, byte-lane
// steering and load formatting. Optional MEM_TIMEOUT_EN adds a REQ-state
// watchdog that aborts an unacknowledged access after TIMEOUT_CYCLES.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ALU_result_MEM,
  input  logic [31:0]       Write_data_MEM,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [1:0]        MemSize_MEM,
  input  logic              MemUnsigned_MEM,
  output logic [31:0]       Read_data_MEM,
  output logic              stall_MEM,
  output logic              align_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  mem_state_t  state;
  ld_ctl_t     ctl;
  logic [1:0]  off;
  logic        valid, misal, err, start, to_hit;
  logic [31:0] ld_data;

  assign off   = ALU_result_MEM[1:0];
  assign valid = MemRead_MEM | MemWrite_MEM;
  // size[1] covers both the word code and the reserved 2'b11
  assign misal = ((MemSize_MEM == SZ_HALF) & off[0]) | (MemSize_MEM[1] & (off != 2'b00));
  assign err   = valid & (misal | (MemRead_MEM & MemWrite_MEM));
  assign start = valid & ~err;

  mem_load_align u_align (
    .rdata  (mem_rdata),
    .off    (ctl.off),
    .size   (ctl.size),
    .uns    (ctl.uns),
    .result (ld_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] to_cnt;

  assign to_hit = (state == ST_REQ) & ~mem_ack & (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: zero outside REQ so every access starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      to_cnt <= '0;
    else if (state != ST_REQ)        to_cnt <= '0;
    else if (!mem_ack)               to_cnt <= to_cnt + 1'b1;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign stall_MEM = ((state == ST_IDLE) & start) | (state == ST_REQ);
  assign align_err = ((state == ST_IDLE) & err) | to_hit;

  // Access sequencer; memory-port outputs are registered and frozen in REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= '0;
      mem_wdata     <= '0;
      Read_data_MEM <= '0;
      ctl           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mem_addr  <= {ALU_result_MEM[ADDR_W-1:2], 2'b00};
            mem_we    <= MemWrite_MEM;
            mem_be    <= byte_en(MemSize_MEM, off);
            mem_wdata <= lane_wdata(MemSize_MEM, Write_data_MEM);
            ctl       <= '{off: off, size: MemSize_MEM, uns: MemUnsigned_MEM, rd: MemRead_MEM};
            mem_req   <= 1'b1;
            state     <= ST_REQ;
          end else if (err) begin
            Read_data_MEM <= '0;
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            Read_data_MEM <= ctl.rd ? ld_data : 32'h0;
            mem_req       <= 1'b0;
            state         <= ST_DONE;
          end else if (to_hit) begin
            Read_data_MEM <= 32'h0;
            mem_req       <= 1'b0;
            state         <= ST_DONE;
          end
        end
        // one free cycle so MEM/WB captures the result; inputs are ignored
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
